// File: rtl/latch_exmem_if.sv
// EX/MEM boundary signals: EX-side capture inputs, hazard controls, the data
// memory handshake, and the registered EX/MEM entry seen by the MEM stage.
interface latch_exmem_if;
    logic        stall;
    logic        flush;
    logic        ex_valid;
    logic [1:0]  ex_WB;
    logic [4:0]  ex_M;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_alu_result;
    logic        ex_zero;
    logic [31:0] ex_rd2;
    logic [31:0] ex_branch_target;
    logic [4:0]  ex_rd;
    logic        mem_ready;

    logic        exmem_valid;
    logic [1:0]  exmem_WB;
    logic        exmem_MemRead;
    logic        exmem_MemWrite;
    logic [31:0] exmem_addr;
    logic [31:0] exmem_store_data;
    logic [3:0]  exmem_byte_en;
    logic [2:0]  exmem_funct3;
    logic [4:0]  exmem_rd;
    logic [31:0] exmem_branch_target;
    logic        exmem_pcsrc;
    logic        exmem_misaligned;
    logic        mem_stall_req;
    logic        mem_timeout;

    modport master (
        output stall, flush, ex_valid, ex_WB, ex_M, ex_funct3, ex_alu_result,
               ex_zero, ex_rd2, ex_branch_target, ex_rd, mem_ready,
        input  exmem_valid, exmem_WB, exmem_MemRead, exmem_MemWrite, exmem_addr,
               exmem_store_data, exmem_byte_en, exmem_funct3, exmem_rd,
               exmem_branch_target, exmem_pcsrc, exmem_misaligned,
               mem_stall_req, mem_timeout
    );

    modport slave (
        input  stall, flush, ex_valid, ex_WB, ex_M, ex_funct3, ex_alu_result,
               ex_zero, ex_rd2, ex_branch_target, ex_rd, mem_ready,
        output exmem_valid, exmem_WB, exmem_MemRead, exmem_MemWrite, exmem_addr,
               exmem_store_data, exmem_byte_en, exmem_funct3, exmem_rd,
               exmem_branch_target, exmem_pcsrc, exmem_misaligned,
               mem_stall_req, mem_timeout
    );
endinterface

// File: rtl/latch_exmem.sv
// EX/MEM pipeline register: store lane alignment, misalignment detection,
// registered branch decision and a bounded wait on the data memory.
module latch_exmem #(
    parameter int MEM_TIMEOUT = 16
) (
    input logic         clock,
    input logic         reset_n,
    latch_exmem_if.slave bus
);
    typedef enum logic {S_IDLE, S_WAIT} state_t;

    localparam logic [7:0] TMO = 8'(MEM_TIMEOUT);

    state_t      state, state_nx;
    logic [7:0]  cnt, cnt_nx;
    logic        access, hold, load_en;

    logic        cap_valid, mem_op, mis_raw, cap_mis, cap_read, cap_write;
    logic        cond, cap_pcsrc;
    logic [1:0]  offs, cap_wb;
    logic [3:0]  be_raw, cap_be;
    logic [31:0] cap_sd;

    // ex_M[0] is reserved and intentionally has no effect.
    logic unused_m0;
    assign unused_m0 = bus.ex_M[0];

    assign access            = bus.exmem_valid & (bus.exmem_MemRead | bus.exmem_MemWrite);
    assign bus.mem_timeout   = (state == S_WAIT) && (cnt == TMO);
    assign bus.mem_stall_req = access & ~bus.mem_ready & ~bus.mem_timeout;
    assign hold              = bus.stall | bus.mem_stall_req;
    // Flush beats hold: a flush always loads, with the valid bit cleared.
    assign load_en           = bus.flush | ~hold;

    // NOTE: every variable written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        offs      = bus.ex_alu_result[1:0];
        cap_valid = bus.ex_valid & ~bus.flush;
        mem_op    = cap_valid & (bus.ex_M[4] | bus.ex_M[3]);
        be_raw    = 4'b1111;
        cap_sd    = bus.ex_rd2;
        mis_raw   = 1'b0;
        case (bus.ex_funct3[1:0])
            2'b00: begin
                be_raw = 4'b0001 << offs;
                cap_sd = {4{bus.ex_rd2[7:0]}};
            end
            2'b01: begin
                be_raw  = 4'b0011 << offs;
                cap_sd  = {2{bus.ex_rd2[15:0]}};
                mis_raw = offs[0];
            end
            default: begin
                be_raw  = 4'b1111;
                cap_sd  = bus.ex_rd2;
                mis_raw = (offs != 2'b00);
            end
        endcase
        // Alignment only matters for loads/stores; branches reuse funct3.
        cap_mis   = mem_op & mis_raw;
        cap_read  = cap_valid & bus.ex_M[4] & ~cap_mis;
        cap_write = cap_valid & bus.ex_M[3] & ~cap_mis;
        cap_be    = cap_write ? be_raw : 4'b0000;
        cap_wb    = cap_valid ? {bus.ex_WB[1] & ~cap_mis, bus.ex_WB[0]} : 2'b00;
        // ALU leaves the signed/unsigned compare in bit 0; funct3[0] inverts.
        cond      = bus.ex_funct3[2] ? (bus.ex_alu_result[0] ^ bus.ex_funct3[0])
                                     : (bus.ex_zero ^ bus.ex_funct3[0]);
        cap_pcsrc = cap_valid & (bus.ex_M[1] | (bus.ex_M[2] & cond));
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bus.exmem_valid         <= 1'b0;
            bus.exmem_WB            <= 2'b00;
            bus.exmem_MemRead       <= 1'b0;
            bus.exmem_MemWrite      <= 1'b0;
            bus.exmem_addr          <= '0;
            bus.exmem_store_data    <= '0;
            bus.exmem_byte_en       <= '0;
            bus.exmem_funct3        <= '0;
            bus.exmem_rd            <= '0;
            bus.exmem_branch_target <= '0;
            bus.exmem_pcsrc         <= 1'b0;
            bus.exmem_misaligned    <= 1'b0;
        end else if (load_en) begin
            bus.exmem_valid         <= cap_valid;
            bus.exmem_WB            <= cap_wb;
            bus.exmem_MemRead       <= cap_read;
            bus.exmem_MemWrite      <= cap_write;
            bus.exmem_addr          <= bus.ex_alu_result;
            bus.exmem_store_data    <= cap_sd;
            bus.exmem_byte_en       <= cap_be;
            bus.exmem_funct3        <= bus.ex_funct3;
            bus.exmem_rd            <= bus.ex_rd;
            bus.exmem_branch_target <= bus.ex_branch_target;
            bus.exmem_pcsrc         <= cap_pcsrc;
            bus.exmem_misaligned    <= cap_mis;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            S_IDLE: begin
                if (access && !bus.mem_ready) begin
                    state_nx = S_WAIT;
                    cnt_nx   = 8'd1;
                end
            end
            S_WAIT: begin
                if (bus.mem_timeout || bus.mem_ready) begin
                    state_nx = S_IDLE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + 8'd1;
                end
            end
            default: begin
                state_nx = S_IDLE;
                cnt_nx   = '0;
            end
        endcase
        if (bus.flush) begin
            state_nx = S_IDLE;
            cnt_nx   = '0;
        end
    end
endmodule

// File: tb/tb_latch_exmem.sv
// Directed bench for latch_exmem: expected entries are queued when driven and
// compared after the capturing edge; memory waits, timeout, flush and reset.
module tb_latch_exmem;
    logic clock = 1'b0;
    logic reset_n;
    always #5 clock = ~clock;

    latch_exmem_if bus ();
    latch_exmem #(.MEM_TIMEOUT(4)) dut (.clock(clock), .reset_n(reset_n), .bus(bus));

    typedef struct {
        logic        valid;
        logic [1:0]  wb;
        logic        mr, mw;
        logic [31:0] addr, sd;
        logic [3:0]  be;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic [31:0] tgt;
        logic        pcsrc, mis;
    } exp_t;

    exp_t sb[$];
    int compared = 0;
    int mismatched = 0;

    function automatic exp_t ent(logic v, logic [1:0] wb, logic mr, logic mw,
                                 logic [31:0] addr, logic [31:0] sd, logic [3:0] be,
                                 logic [2:0] f3, logic [4:0] rd, logic [31:0] tgt,
                                 logic pc, logic mis);
        exp_t e;
        e.valid = v; e.wb = wb; e.mr = mr; e.mw = mw; e.addr = addr; e.sd = sd;
        e.be = be; e.f3 = f3; e.rd = rd; e.tgt = tgt; e.pcsrc = pc; e.mis = mis;
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] wb, input logic [4:0] m,
                         input logic [2:0] f3, input logic [31:0] alu, input logic z,
                         input logic [31:0] rd2, input logic [31:0] tgt, input logic [4:0] rd);
        bus.ex_valid = v; bus.ex_WB = wb; bus.ex_M = m; bus.ex_funct3 = f3;
        bus.ex_alu_result = alu; bus.ex_zero = z; bus.ex_rd2 = rd2;
        bus.ex_branch_target = tgt; bus.ex_rd = rd;
    endtask

    task automatic drive_lw(input logic [31:0] addr, input logic [4:0] rd);
        drive(1'b1, 2'b11, 5'b10000, 3'b010, addr, 1'b0, 32'h0, 32'h0, rd);
        sb.push_back(ent(1'b1, 2'b11, 1'b1, 1'b0, addr, 32'h0, 4'b0000, 3'b010, rd, 32'h0, 1'b0, 1'b0));
    endtask

    task automatic drive_idle();
        drive(1'b0, 2'b00, 5'b00000, 3'b000, 32'h0, 1'b0, 32'h0, 32'h0, 5'd0);
    endtask

    task automatic check_entry(input string tag);
        exp_t e;
        compared++;
        assert (sb.size() > 0) else begin
            mismatched++;
            $error("FAIL %s/scoreboard: observed empty queue expected an entry", tag);
        end
        if (sb.size() == 0) return;
        e = sb.pop_front();
        check({tag, "/valid"}, 32'(bus.exmem_valid), 32'(e.valid));
        check({tag, "/wb"}, 32'(bus.exmem_WB), 32'(e.wb));
        check({tag, "/memread"}, 32'(bus.exmem_MemRead), 32'(e.mr));
        check({tag, "/memwrite"}, 32'(bus.exmem_MemWrite), 32'(e.mw));
        check({tag, "/addr"}, bus.exmem_addr, e.addr);
        check({tag, "/store_data"}, bus.exmem_store_data, e.sd);
        check({tag, "/byte_en"}, 32'(bus.exmem_byte_en), 32'(e.be));
        check({tag, "/funct3"}, 32'(bus.exmem_funct3), 32'(e.f3));
        check({tag, "/rd"}, 32'(bus.exmem_rd), 32'(e.rd));
        check({tag, "/target"}, bus.exmem_branch_target, e.tgt);
        check({tag, "/pcsrc"}, 32'(bus.exmem_pcsrc), 32'(e.pcsrc));
        check({tag, "/misaligned"}, 32'(bus.exmem_misaligned), 32'(e.mis));
    endtask

    task automatic check_zero(input string tag);
        check({tag, "/valid"}, 32'(bus.exmem_valid), 32'h0);
        check({tag, "/wb"}, 32'(bus.exmem_WB), 32'h0);
        check({tag, "/memread"}, 32'(bus.exmem_MemRead), 32'h0);
        check({tag, "/memwrite"}, 32'(bus.exmem_MemWrite), 32'h0);
        check({tag, "/addr"}, bus.exmem_addr, 32'h0);
        check({tag, "/store_data"}, bus.exmem_store_data, 32'h0);
        check({tag, "/byte_en"}, 32'(bus.exmem_byte_en), 32'h0);
        check({tag, "/funct3"}, 32'(bus.exmem_funct3), 32'h0);
        check({tag, "/rd"}, 32'(bus.exmem_rd), 32'h0);
        check({tag, "/target"}, bus.exmem_branch_target, 32'h0);
        check({tag, "/pcsrc"}, 32'(bus.exmem_pcsrc), 32'h0);
        check({tag, "/misaligned"}, 32'(bus.exmem_misaligned), 32'h0);
        check({tag, "/stall_req"}, 32'(bus.mem_stall_req), 32'h0);
        check({tag, "/timeout"}, 32'(bus.mem_timeout), 32'h0);
    endtask

    // Entered in the first cycle a load is visible with mem_ready low; with
    // MEM_TIMEOUT=4 the pulse lands on the 4th WAIT cycle.
    task automatic expect_timeout(input string tag, input logic [31:0] addr);
        for (int i = 0; i < 4; i++) begin
            check({tag, "/stall"}, 32'(bus.mem_stall_req), 32'h1);
            check({tag, "/no_timeout"}, 32'(bus.mem_timeout), 32'h0);
            check({tag, "/held"}, bus.exmem_addr, addr);
            tick();
        end
        check({tag, "/timeout"}, 32'(bus.mem_timeout), 32'h1);
        check({tag, "/stall_drop"}, 32'(bus.mem_stall_req), 32'h0);
    endtask

    initial begin
        reset_n = 1'b0;
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        bus.mem_ready = 1'b1;
        drive_idle();
        #2;
        check_zero("reset");
        #10 reset_n = 1'b1;
        tick();

        // SB to offset 3: top lane only, byte replicated.
        drive(1'b1, 2'b00, 5'b01000, 3'b000, 32'h1003, 1'b0, 32'h000000A5, 32'h0, 5'd0);
        sb.push_back(ent(1'b1, 2'b00, 1'b0, 1'b1, 32'h1003, 32'hA5A5A5A5, 4'b1000, 3'b000, 5'd0, 32'h0, 1'b0, 1'b0));
        tick();
        drive(1'b1, 2'b11, 5'b10000, 3'b010, 32'h1002, 1'b0, 32'h12345678, 32'h0, 5'd5);
        sb.push_back(ent(1'b1, 2'b01, 1'b0, 1'b0, 32'h1002, 32'h12345678, 4'b0000, 3'b010, 5'd5, 32'h0, 1'b0, 1'b1));
        #1 check_entry("sb");
        check("sb/stall_req", 32'(bus.mem_stall_req), 32'h0);
        tick();
        drive(1'b1, 2'b00, 5'b00100, 3'b001, 32'h0, 1'b0, 32'h0, 32'h20000040, 5'd0);
        sb.push_back(ent(1'b1, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 4'b0000, 3'b001, 5'd0, 32'h20000040, 1'b1, 1'b0));
        #1 check_entry("lw_misaligned");
        check("lw_misaligned/stall_req", 32'(bus.mem_stall_req), 32'h0);
        tick();
        drive(1'b1, 2'b00, 5'b00100, 3'b000, 32'h0, 1'b0, 32'h0, 32'h20000080, 5'd0);
        sb.push_back(ent(1'b1, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 4'b0000, 3'b000, 5'd0, 32'h20000080, 1'b0, 1'b0));
        #1 check_entry("bne_taken");
        tick();
        drive(1'b1, 2'b10, 5'b00010, 3'b000, 32'h104, 1'b0, 32'h0, 32'h30000000, 5'd1);
        sb.push_back(ent(1'b1, 2'b10, 1'b0, 1'b0, 32'h104, 32'h0, 4'b0000, 3'b000, 5'd1, 32'h30000000, 1'b1, 1'b0));
        #1 check_entry("beq_not_taken");
        tick();
        drive(1'b1, 2'b00, 5'b00100, 3'b100, 32'h1, 1'b0, 32'h0, 32'h20000100, 5'd0);
        sb.push_back(ent(1'b1, 2'b00, 1'b0, 1'b0, 32'h1, 32'h0, 4'b0000, 3'b100, 5'd0, 32'h20000100, 1'b1, 1'b0));
        #1 check_entry("jump");
        tick();
        drive(1'b1, 2'b00, 5'b00100, 3'b111, 32'h1, 1'b0, 32'h0, 32'h20000200, 5'd0);
        sb.push_back(ent(1'b1, 2'b00, 1'b0, 1'b0, 32'h1, 32'h0, 4'b0000, 3'b111, 5'd0, 32'h20000200, 1'b0, 1'b0));
        #1 check_entry("blt_taken");
        tick();
        drive(1'b0, 2'b11, 5'b11000, 3'b010, 32'h1001, 1'b1, 32'hDEADBEEF, 32'h40, 5'd6);
        sb.push_back(ent(1'b0, 2'b00, 1'b0, 1'b0, 32'h1001, 32'hDEADBEEF, 4'b0000, 3'b010, 5'd6, 32'h40, 1'b0, 1'b0));
        #1 check_entry("bgeu_not_taken");
        tick();
        drive_lw(32'h2000, 5'd7);
        #1 check_entry("bubble");

        // Memory not ready for three cycles, then ready.
        tick();
        bus.mem_ready = 1'b0;
        drive(1'b1, 2'b00, 5'b01000, 3'b010, 32'h3004, 1'b0, 32'hCAFEF00D, 32'h0, 5'd0);
        sb.push_back(ent(1'b1, 2'b00, 1'b0, 1'b1, 32'h3004, 32'hCAFEF00D, 4'b1111, 3'b010, 5'd0, 32'h0, 1'b0, 1'b0));
        #1 check_entry("lw_wait");
        for (int i = 0; i < 3; i++) begin
            check("wait/stall", 32'(bus.mem_stall_req), 32'h1);
            check("wait/held_addr", bus.exmem_addr, 32'h2000);
            check("wait/held_rd", 32'(bus.exmem_rd), 32'd7);
            tick();
            if (i == 2) bus.mem_ready = 1'b1;
        end
        #1 check("ready/stall", 32'(bus.mem_stall_req), 32'h0);
        tick();
        drive(1'b1, 2'b00, 5'b01000, 3'b001, 32'h3006, 1'b0, 32'h0000BEEF, 32'h0, 5'd0);
        sb.push_back(ent(1'b1, 2'b00, 1'b0, 1'b1, 32'h3006, 32'hBEEFBEEF, 4'b1100, 3'b001, 5'd0, 32'h0, 1'b0, 1'b0));
        #1 check_entry("sw_after_ready");
        check("sw/stall_req", 32'(bus.mem_stall_req), 32'h0);
        tick();
        drive_lw(32'h4000, 5'd9);
        #1 check_entry("sh_upper");

        // Timeout: the next entry loads on the edge after the pulse.
        tick();
        bus.mem_ready = 1'b0;
        drive(1'b1, 2'b10, 5'b00000, 3'b000, 32'h55, 1'b0, 32'h0, 32'h0, 5'd3);
        sb.push_back(ent(1'b1, 2'b10, 1'b0, 1'b0, 32'h55, 32'h0, 4'b0000, 3'b000, 5'd3, 32'h0, 1'b0, 1'b0));
        #1 check_entry("lw_timeout");
        expect_timeout("tmo", 32'h4000);
        tick();
        drive_lw(32'h5000, 5'd8);
        #1 check_entry("after_timeout");
        check("after_timeout/pulse_gone", 32'(bus.mem_timeout), 32'h0);

        // Flush while waiting.
        tick();
        drive(1'b1, 2'b10, 5'b00000, 3'b000, 32'h77, 1'b0, 32'h0, 32'h0, 5'd4);
        #1 check_entry("lw_flush");
        check("flush/stall_c0", 32'(bus.mem_stall_req), 32'h1);
        tick();
        check("flush/stall_c1", 32'(bus.mem_stall_req), 32'h1);
        tick();
        bus.flush = 1'b1;
        sb.push_back(ent(1'b0, 2'b00, 1'b0, 1'b0, 32'h77, 32'h0, 4'b0000, 3'b000, 5'd4, 32'h0, 1'b0, 1'b0));
        #1 check("flush/stall_c2", 32'(bus.mem_stall_req), 32'h1);
        tick();
        bus.flush = 1'b0;
        drive_lw(32'h6000, 5'd10);
        #1 check_entry("flushed");
        check("flushed/stall_req", 32'(bus.mem_stall_req), 32'h0);
        check("flushed/timeout", 32'(bus.mem_timeout), 32'h0);
        tick();
        drive_idle();
        sb.push_back(ent(1'b0, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 4'b0000, 3'b000, 5'd0, 32'h0, 1'b0, 1'b0));
        #1 check_entry("lw_after_flush");
        expect_timeout("tmo_after_flush", 32'h6000);

        // Asynchronous reset in the middle of a wait.
        tick();
        drive_lw(32'h7000, 5'd11);
        #1 check_entry("idle");
        tick();
        drive_idle();
        #1 check_entry("lw_reset");
        tick();
        check("reset_wait/stall", 32'(bus.mem_stall_req), 32'h1);
        #2 reset_n = 1'b0;
        #1 check_zero("mid_wait_reset");
        #2 reset_n = 1'b1;
        tick();
        drive_lw(32'h8000, 5'd12);
        tick();
        drive_idle();
        #1 check_entry("lw_post_reset");
        expect_timeout("tmo_post_reset", 32'h8000);

        // Hazard-unit stall holds the entry.
        tick();
        bus.mem_ready = 1'b1;
        drive(1'b1, 2'b10, 5'b00000, 3'b000, 32'h99, 1'b0, 32'h0, 32'h0, 5'd13);
        sb.push_back(ent(1'b1, 2'b10, 1'b0, 1'b0, 32'h99, 32'h0, 4'b0000, 3'b000, 5'd13, 32'h0, 1'b0, 1'b0));
        tick();
        bus.stall = 1'b1;
        drive(1'b1, 2'b10, 5'b00000, 3'b000, 32'hAA, 1'b0, 32'h0, 32'h0, 5'd14);
        #1 check_entry("pre_stall");
        tick();
        check("stall/held_addr", bus.exmem_addr, 32'h99);
        check("stall/held_rd", 32'(bus.exmem_rd), 32'd13);
        bus.stall = 1'b0;
        sb.push_back(ent(1'b1, 2'b10, 1'b0, 1'b0, 32'hAA, 32'h0, 4'b0000, 3'b000, 5'd14, 32'h0, 1'b0, 1'b0));
        tick();
        #1 check_entry("post_stall");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
